// File: rtl/up_pkg.sv
// up_pkg: widths and FSM state encoding shared by the RAM arbiter and
// anything else that talks to the 4096x4 RAM.
package up_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 4;
    localparam int WAIT_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_ACC = 2'd1,
        DBG_ACC = 2'd2
    } arb_state_t;

    // Saturating increment used by the debug starvation counter.
    function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] val,
                                                  input logic [WAIT_W-1:0] limit);
        logic [WAIT_W-1:0] res;
        if (val >= limit) begin
            res = limit;
        end else begin
            res = val + 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/ram_arbiter.sv
// ram_arbiter: single-cycle arbiter placing a CPU port and a debug/loader
// port in front of an external 4096x4 RAM with a combinational read.
// The CPU has fixed priority; a debug request refused MAX_WAIT cycles in a
// row is forced through on the next cycle.
// Build option: define RAM_ARB_STATS_EN to add the per-port grant counters
// cpu_cnt / dbg_cnt.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no access this cycle, RAM bus parked at zero
// CPU_ACC | RAM bus carries the CPU access, cpu_gnt high
// DBG_ACC | RAM bus carries the debug access, dbg_gnt high
module ram_arbiter
    import up_pkg::*;
#(
    parameter int MAX_WAIT = 8
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,

`ifdef RAM_ARB_STATS_EN
    output logic [15:0]       cpu_cnt,
    output logic [15:0]       dbg_cnt,
`endif

    output logic              ram_cs,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    arb_state_t        state_q;
    arb_state_t        state_d;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_cnt_d;
    logic              dbg_forced;
    logic              cpu_win;
    logic              dbg_win;
    logic              cpu_rd_done;
    logic              dbg_rd_done;

    // Pick this cycle's winner; debug only overtakes the CPU once starved.
    always_comb begin
        dbg_forced = dbg_req && (wait_cnt == WAIT_LIMIT);
        cpu_win    = cpu_req && !dbg_forced;
        dbg_win    = dbg_req && !cpu_win;
        state_d    = IDLE;
        if (cpu_win) begin
            state_d = CPU_ACC;
        end else if (dbg_win) begin
            state_d = DBG_ACC;
        end
    end

    // Next starvation count: grows while debug waits, clears otherwise.
    always_comb begin
        wait_cnt_d = '0;
        if (dbg_req && !dbg_win) begin
            wait_cnt_d = sat_inc(wait_cnt, WAIT_LIMIT);
        end
    end

    // FSM state and starvation counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            wait_cnt <= '0;
        end else begin
            state_q  <= state_d;
            wait_cnt <= wait_cnt_d;
        end
    end

    // Register the winner's access onto the RAM bus; park the bus at zero otherwise.
    always_ff @(posedge clock) begin
        if (reset) begin
            ram_cs    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else if (cpu_win) begin
            ram_cs    <= 1'b1;
            ram_we    <= cpu_we;
            ram_addr  <= cpu_addr;
            ram_wdata <= cpu_wdata;
        end else if (dbg_win) begin
            ram_cs    <= 1'b1;
            ram_we    <= dbg_we;
            ram_addr  <= dbg_addr;
            ram_wdata <= dbg_wdata;
        end else begin
            ram_cs    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end
    end

    // Grants are a straight decode of the registered state, so they last
    // exactly the one access cycle.
    assign cpu_gnt = (state_q == CPU_ACC);
    assign dbg_gnt = (state_q == DBG_ACC);

    assign cpu_rd_done = (state_q == CPU_ACC) && !ram_we;
    assign dbg_rd_done = (state_q == DBG_ACC) && !ram_we;

    // Capture read data at the end of the access cycle; rdata holds until
    // that port's next read.
    always_ff @(posedge clock) begin
        if (reset) begin
            cpu_rvalid <= 1'b0;
            dbg_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            dbg_rdata  <= '0;
        end else begin
            cpu_rvalid <= cpu_rd_done;
            dbg_rvalid <= dbg_rd_done;
            if (cpu_rd_done) begin
                cpu_rdata <= ram_rdata;
            end
            if (dbg_rd_done) begin
                dbg_rdata <= ram_rdata;
            end
        end
    end

`ifdef RAM_ARB_STATS_EN
    // Grant counters; wrap naturally at 16 bits.
    always_ff @(posedge clock) begin
        if (reset) begin
            cpu_cnt <= '0;
            dbg_cnt <= '0;
        end else begin
            if (cpu_win) begin
                cpu_cnt <= cpu_cnt + 16'd1;
            end
            if (dbg_win) begin
                dbg_cnt <= dbg_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
